// File: rtl/id_stage_if.sv
// IF/ID -> ID/EX bundle interface for the dual-slot VLIW decode stage.
// master drives the fetched bundle and flush inputs; slave (id_stage) drives control and ID/EX.
interface id_stage_if;
  logic [15:0] p1_aluInstr;
  logic [15:0] p1_memInstr;
  logic [31:0] if_pc;
  logic        ex_branchTaken;
  logic        isException;

  logic        pcWrite;
  logic        p1_pipeline_regWrite;
  logic        isJump;
  logic [31:0] pc_jumpTarget;
  logic [31:0] pc_branchTarget;
  logic        p2_isBranch;
  logic        p2_valid;
  logic [3:0]  p2_aluOp;
  logic [3:0]  p2_aluRd;
  logic [3:0]  p2_aluRs;
  logic [3:0]  p2_aluRt;
  logic [1:0]  p2_memOp;
  logic [3:0]  p2_memRd;
  logic [3:0]  p2_memRs;
  logic [3:0]  p2_memImm;
  logic [15:0] stall_count;

  modport master (
    output p1_aluInstr, p1_memInstr, if_pc, ex_branchTaken, isException,
    input  pcWrite, p1_pipeline_regWrite, isJump, pc_jumpTarget, pc_branchTarget,
           p2_isBranch, p2_valid, p2_aluOp, p2_aluRd, p2_aluRs, p2_aluRt,
           p2_memOp, p2_memRd, p2_memRs, p2_memImm, stall_count
  );

  modport slave (
    input  p1_aluInstr, p1_memInstr, if_pc, ex_branchTaken, isException,
    output pcWrite, p1_pipeline_regWrite, isJump, pc_jumpTarget, pc_branchTarget,
           p2_isBranch, p2_valid, p2_aluOp, p2_aluRd, p2_aluRs, p2_aluRt,
           p2_memOp, p2_memRd, p2_memRs, p2_memImm, stall_count
  );
endinterface

// File: rtl/id_stage.sv
// Decode stage: splits the ALU/MEM bundle into ID/EX fields, handles load-use stalls,
// jumps, taken-branch and exception squashes. Flush priority: exception > branch > hazard > jump.
module id_stage (
  input  logic       clk,
  input  logic       reset,
  id_stage_if.slave  bus
);
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, SQUASH = 2'd2} state_e;
  state_e state_q, state_d;

  logic [3:0] alu_op, alu_rd, alu_rs, alu_rt;
  logic [3:0] mem_op, mem_rd, mem_rs, mem_imm;
  assign {alu_op, alu_rd, alu_rs, alu_rt} = bus.p1_aluInstr;
  assign {mem_op, mem_rd, mem_rs, mem_imm} = bus.p1_memInstr;

  logic alu_is_op, alu_is_brn, alu_is_jmp, mem_is_lw, mem_is_sw, mem_is_op;
  assign alu_is_op  = (alu_op != 4'd0) && (alu_op <= 4'd11);
  assign alu_is_brn = (alu_op == 4'd12);
  assign alu_is_jmp = (alu_op == 4'd13);
  assign mem_is_lw  = (mem_op == 4'd1);
  assign mem_is_sw  = (mem_op == 4'd2);
  assign mem_is_op  = mem_is_lw || mem_is_sw;

  logic [31:0] branch_target;
  assign branch_target = bus.if_pc + 32'd4 + {{22{bus.p1_aluInstr[7]}}, bus.p1_aluInstr[7:0], 2'b00};
  assign bus.pc_jumpTarget = {bus.if_pc[31:14], bus.p1_aluInstr[11:0], 2'b00};

  // Only a LW sitting in ID/EX can hazard; after a stall or squash ID/EX holds a bubble.
  logic load_use, flush;
  assign load_use = (state_q == RUN) && bus.p2_valid && (bus.p2_memOp == 2'b01) &&
                    (bus.p2_memRd != 4'd0) &&
                    ((alu_is_op && ((bus.p2_memRd == alu_rs) || (bus.p2_memRd == alu_rt))) ||
                     (mem_is_op && (bus.p2_memRd == mem_rs)) ||
                     (mem_is_sw && (bus.p2_memRd == mem_rd)));
  assign flush = bus.isException || bus.ex_branchTaken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    if (flush)                    state_d = SQUASH;
    else if (state_q == SQUASH)   state_d = RUN;
    else if (load_use)            state_d = LU_STALL;
    else if (alu_is_jmp)          state_d = SQUASH;
  end

  logic stall, bubble, take_jump;
  always_comb begin
    stall     = 1'b0;
    bubble    = 1'b0;
    take_jump = 1'b0;
    if (reset || flush || (state_q == SQUASH)) begin
      bubble = 1'b1;
    end else if (load_use) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end else begin
      take_jump = alu_is_jmp;
    end
  end

  assign bus.pcWrite              = !stall;
  assign bus.p1_pipeline_regWrite = !stall;
  assign bus.isJump               = take_jump;

  logic        valid_q, valid_d, isbr_q, isbr_d;
  logic [3:0]  aluop_q, aluop_d, alurd_q, alurd_d, alurs_q, alurs_d, alurt_q, alurt_d;
  logic [1:0]  memop_q, memop_d;
  logic [3:0]  memrd_q, memrd_d, memrs_q, memrs_d, memimm_q, memimm_d;
  logic [31:0] bt_q, bt_d;
  logic [15:0] sc_q, sc_d;

  // BRN/JMP/NOP in the ALU slot reach EX as an all-zero ALU NOP.
  always_comb begin
    valid_d  = !bubble;
    isbr_d   = 1'b0;
    aluop_d  = 4'd0;
    alurd_d  = 4'd0;
    alurs_d  = 4'd0;
    alurt_d  = 4'd0;
    memop_d  = 2'b00;
    memrd_d  = 4'd0;
    memrs_d  = 4'd0;
    memimm_d = 4'd0;
    bt_d     = bt_q;
    if (!bubble) begin
      if (alu_is_op) begin
        aluop_d = alu_op;
        alurd_d = alu_rd;
        alurs_d = alu_rs;
        alurt_d = alu_rt;
      end
      if (alu_is_brn) begin
        isbr_d = 1'b1;
        bt_d   = branch_target;
      end
      if (mem_is_op) begin
        memop_d  = mem_op[1:0];
        memrd_d  = mem_rd;
        memrs_d  = mem_rs;
        memimm_d = mem_imm;
      end
    end
    sc_d = (stall && (sc_q != 16'hFFFF)) ? sc_q + 16'd1 : sc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      isbr_q   <= 1'b0;
      aluop_q  <= 4'd0;
      alurd_q  <= 4'd0;
      alurs_q  <= 4'd0;
      alurt_q  <= 4'd0;
      memop_q  <= 2'b00;
      memrd_q  <= 4'd0;
      memrs_q  <= 4'd0;
      memimm_q <= 4'd0;
      bt_q     <= 32'd0;
      sc_q     <= 16'd0;
    end else begin
      valid_q  <= valid_d;
      isbr_q   <= isbr_d;
      aluop_q  <= aluop_d;
      alurd_q  <= alurd_d;
      alurs_q  <= alurs_d;
      alurt_q  <= alurt_d;
      memop_q  <= memop_d;
      memrd_q  <= memrd_d;
      memrs_q  <= memrs_d;
      memimm_q <= memimm_d;
      bt_q     <= bt_d;
      sc_q     <= sc_d;
    end
  end

  assign bus.p2_valid        = valid_q;
  assign bus.p2_isBranch     = isbr_q;
  assign bus.p2_aluOp        = aluop_q;
  assign bus.p2_aluRd        = alurd_q;
  assign bus.p2_aluRs        = alurs_q;
  assign bus.p2_aluRt        = alurt_q;
  assign bus.p2_memOp        = memop_q;
  assign bus.p2_memRd        = memrd_q;
  assign bus.p2_memRs        = memrs_q;
  assign bus.p2_memImm       = memimm_q;
  assign bus.pc_branchTarget = bt_q;
  assign bus.stall_count     = sc_q;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, hand-written reset corner cases,
// then random bundles checked against a behavioural pipeline model.
module tb_id_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_stage_if bus ();
  id_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] m, input logic [31:0] pc,
                       input logic br, input logic exc);
    bus.p1_aluInstr    = a;
    bus.p1_memInstr    = m;
    bus.if_pc          = pc;
    bus.ex_branchTaken = br;
    bus.isException    = exc;
  endtask

  typedef struct packed {
    logic       valid;
    logic [3:0] aluOp, aluRd, aluRs, aluRt;
    logic [1:0] memOp;
    logic [3:0] memRd, memRs, memImm;
    logic       isBr;
  } p2_t;

  function automatic p2_t p2_now();
    return {bus.p2_valid, bus.p2_aluOp, bus.p2_aluRd, bus.p2_aluRs, bus.p2_aluRt,
            bus.p2_memOp, bus.p2_memRd, bus.p2_memRs, bus.p2_memImm, bus.p2_isBranch};
  endfunction

  typedef struct {
    logic [15:0] alu, mem;
    logic [31:0] pc;
    logic        br, exc;
    logic        e_pcw, e_jmp, e_valid;
    logic [3:0]  e_aluop;
    logic [1:0]  e_memop;
    logic [15:0] e_sc;
    logic        e_isbr;
    logic [31:0] e_tgt;
  } vec_t;
  vec_t tbl[18];

  // Behavioural model state: expected ID/EX contents, pending squash, counters.
  p2_t         m_p2;
  logic        m_squash;
  logic [31:0] m_bt;
  int          m_sc;

  initial begin
    logic [15:0] alu, mem;
    logic [31:0] pc;
    logic br, exc, rst_now, hold, e_pcw, e_j, hz;
    logic [3:0] aop, mop;
    logic signed [7:0] off8;
    p2_t nxt;
    int srcs[$];

    tbl[0]  = '{16'h0000, 16'h1300, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd1, 16'd0, 1'b0, 32'h0};
    tbl[1]  = '{16'h1532, 16'h0000, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 16'd1, 1'b0, 32'h0};
    tbl[2]  = '{16'h1532, 16'h0000, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 2'd0, 16'd1, 1'b0, 32'h0};
    tbl[3]  = '{16'h0000, 16'h1000, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd1, 16'd1, 1'b0, 32'h0};
    tbl[4]  = '{16'h1500, 16'h0000, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 2'd0, 16'd1, 1'b0, 32'h0};
    tbl[5]  = '{16'hD123, 16'h2456, 32'h4000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 2'd2, 16'd1, 1'b0, 32'h448C};
    tbl[6]  = '{16'h2111, 16'h0000, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 16'd1, 1'b0, 32'h0};
    tbl[7]  = '{16'hC0FE, 16'h0000, 32'h100,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd0, 16'd1, 1'b1, 32'hFC};
    tbl[8]  = '{16'h3123, 16'h0000, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 16'd1, 1'b0, 32'h0};
    tbl[9]  = '{16'h3123, 16'h0000, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 16'd1, 1'b0, 32'h0};
    tbl[10] = '{16'h3123, 16'h0000, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 2'd0, 16'd1, 1'b0, 32'h0};
    tbl[11] = '{16'h0000, 16'h1300, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd1, 16'd1, 1'b0, 32'h0};
    tbl[12] = '{16'hD123, 16'h2300, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 16'd1, 1'b0, 32'h0};
    tbl[13] = '{16'h1532, 16'h0000, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 16'd1, 1'b0, 32'h0};
    tbl[14] = '{16'h1532, 16'h0000, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 2'd0, 16'd1, 1'b0, 32'h0};
    tbl[15] = '{16'h0000, 16'h1700, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd1, 16'd1, 1'b0, 32'h0};
    tbl[16] = '{16'h0000, 16'h2170, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 16'd2, 1'b0, 32'h0};
    tbl[17] = '{16'h0000, 16'h2170, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd2, 16'd2, 1'b0, 32'h0};

    // Reset with a JMP bundle presented: isJump must stay low.
    reset = 1'b1;
    drive(16'hD123, 16'h1300, 32'h4000, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rst_isJump", bus.isJump, 1'b0);
    chk("rst_pcWrite", bus.pcWrite, 1'b1);
    chk("rst_regWrite", bus.p1_pipeline_regWrite, 1'b1);
    chk("rst_p2", p2_now(), 32'h0);
    chk("rst_bt", bus.pc_branchTarget, 32'h0);
    chk("rst_sc", bus.stall_count, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i].alu, tbl[i].mem, tbl[i].pc, tbl[i].br, tbl[i].exc);
      #1;
      chk($sformatf("vec%0d_pcWrite", i), bus.pcWrite, tbl[i].e_pcw);
      chk($sformatf("vec%0d_regWrite", i), bus.p1_pipeline_regWrite, tbl[i].e_pcw);
      chk($sformatf("vec%0d_isJump", i), bus.isJump, tbl[i].e_jmp);
      if (tbl[i].e_jmp) chk($sformatf("vec%0d_jumpTarget", i), bus.pc_jumpTarget, tbl[i].e_tgt);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), bus.p2_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d_aluOp", i), bus.p2_aluOp, tbl[i].e_aluop);
      chk($sformatf("vec%0d_memOp", i), bus.p2_memOp, tbl[i].e_memop);
      chk($sformatf("vec%0d_stall_count", i), bus.stall_count, tbl[i].e_sc);
      chk($sformatf("vec%0d_isBranch", i), bus.p2_isBranch, tbl[i].e_isbr);
      if (tbl[i].e_isbr) chk($sformatf("vec%0d_branchTarget", i), bus.pc_branchTarget, tbl[i].e_tgt);
    end

    // Asynchronous reset while in LU_STALL, then while in SQUASH.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    drive(16'h0000, 16'h1300, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(16'hD123, 16'h2300, 32'h4000, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("lu_isJump", bus.isJump, 1'b1);
    chk("lu_sc", bus.stall_count, 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_isJump", bus.isJump, 1'b0);
    chk("async_pcWrite", bus.pcWrite, 1'b1);
    chk("async_regWrite", bus.p1_pipeline_regWrite, 1'b1);
    chk("async_sc", bus.stall_count, 16'd0);
    chk("async_p2", p2_now(), 32'h0);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("post_rst_isJump", bus.isJump, 1'b1);
    @(posedge clk); #1;
    chk("post_rst_memOp", bus.p2_memOp, 2'd2);
    #2 reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    drive(16'h3123, 16'h0000, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("squash_abandon_valid", bus.p2_valid, 1'b1);
    chk("squash_abandon_aluOp", bus.p2_aluOp, 4'd3);

    // Random phase against the model, starting from a clean reset.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_p2 = '0; m_squash = 1'b0; m_bt = 32'h0; m_sc = 0;
    hold = 1'b0;
    alu = 16'h0; mem = 16'h0; pc = 32'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (!hold) begin
        aop = 4'($urandom_range(0, 15));
        if (aop >= 4'd12) alu = {aop, 12'($urandom)};
        else alu = {aop, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
        mem = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)};
        pc  = $urandom;
      end
      br      = ($urandom_range(0, 9) == 0);
      exc     = ($urandom_range(0, 19) == 0);
      rst_now = ($urandom_range(0, 49) == 0);
      reset   = rst_now;
      drive(alu, mem, pc, br, exc);
      #1;
      e_pcw = 1'b1; e_j = 1'b0;
      if (rst_now) begin
        m_p2 = '0; m_squash = 1'b0; m_bt = 32'h0; m_sc = 0;
        chk("rnd_async_p2", p2_now(), 32'h0);
        chk("rnd_async_sc", bus.stall_count, 16'h0);
      end else begin
        aop = alu[15:12];
        mop = mem[15:12];
        srcs = {};
        if (aop >= 4'd1 && aop <= 4'd11) begin srcs.push_back(int'(alu[7:4])); srcs.push_back(int'(alu[3:0])); end
        if (mop == 4'd1 || mop == 4'd2) srcs.push_back(int'(mem[7:4]));
        if (mop == 4'd2) srcs.push_back(int'(mem[11:8]));
        hz = 1'b0;
        if (!m_squash && m_p2.valid && m_p2.memOp == 2'd1 && m_p2.memRd != 4'd0)
          foreach (srcs[k]) if (srcs[k] == int'(m_p2.memRd)) hz = 1'b1;
        nxt = '0;
        if (exc || br) begin
          m_squash = 1'b1;
        end else if (m_squash) begin
          m_squash = 1'b0;
        end else if (hz) begin
          e_pcw = 1'b0;
          if (m_sc < 65535) m_sc++;
        end else begin
          nxt.valid = 1'b1;
          if (aop >= 4'd1 && aop <= 4'd11) begin
            nxt.aluOp = aop; nxt.aluRd = alu[11:8]; nxt.aluRs = alu[7:4]; nxt.aluRt = alu[3:0];
          end
          if (aop == 4'd12) begin
            off8 = alu[7:0];
            nxt.isBr = 1'b1;
            m_bt = pc + 32'd4 + 32'(int'(off8) * 4);
          end
          if (aop == 4'd13) begin
            e_j = 1'b1;
            m_squash = 1'b1;
          end
          if (mop == 4'd1 || mop == 4'd2) begin
            nxt.memOp = mop[1:0]; nxt.memRd = mem[11:8]; nxt.memRs = mem[7:4]; nxt.memImm = mem[3:0];
          end
        end
        m_p2 = nxt;
      end
      chk($sformatf("rnd%0d_pcWrite", cyc), bus.pcWrite, e_pcw);
      chk($sformatf("rnd%0d_regWrite", cyc), bus.p1_pipeline_regWrite, e_pcw);
      chk($sformatf("rnd%0d_isJump", cyc), bus.isJump, e_j);
      chk($sformatf("rnd%0d_jumpTarget", cyc), bus.pc_jumpTarget,
          (pc & 32'hFFFF_C000) | ({20'd0, alu[11:0]} << 2));
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_p2", cyc), p2_now(), m_p2);
      chk($sformatf("rnd%0d_branchTarget", cyc), bus.pc_branchTarget, m_bt);
      chk($sformatf("rnd%0d_stall_count", cyc), bus.stall_count, 16'(m_sc));
      hold = !e_pcw;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
